// File: rtl/coef_seq_pkg.sv
// Shared types and defaults for the stereo coefficient RAM sequencer.
// Holds the controller state encoding and RAM side-select constants.
package coef_seq_pkg;

  localparam int BLK_AW_D = 11;
  localparam int RW_AW_D  = 14;
  localparam int DW_D     = 36;

  localparam logic SEL_L = 1'b0;
  localparam logic SEL_R = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SWEEP = 3'd1,
    ST_HWR   = 3'd2,
    ST_HRD1  = 3'd3,
    ST_HRD2  = 3'd4
  } state_e;

endpackage

// File: rtl/coef_host_port.sv
// Host command slot for the coefficient RAM rw ports.
// Holds one command, drives the rw side when granted, returns ack/rdata.
module coef_host_port
  import coef_seq_pkg::*;
#(
  parameter int RW_AW = RW_AW_D,
  parameter int DW    = DW_D
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             we_i,
  input  logic             sel_i,
  input  logic [RW_AW-1:0] addr_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic             go_wr_i,
  input  logic             go_rd_i,
  input  logic             rd_cap_i,
  output logic             pend_o,
  output logic             slot_we_o,
  output logic             ready_o,
  output logic             ack_o,
  output logic [DW-1:0]    rdata_o,
  output logic [RW_AW-1:0] addr_l_o,
  output logic [RW_AW-1:0] addr_r_o,
  output logic [DW-1:0]    din_l_o,
  output logic [DW-1:0]    din_r_o,
  output logic             we_l_o,
  output logic             we_r_o,
  input  logic [DW-1:0]    dout_l_i,
  input  logic [DW-1:0]    dout_r_i
);

  logic             s_we_q, s_we_d;
  logic             s_sel_q, s_sel_d;
  logic [RW_AW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0]    s_wdata_q, s_wdata_d;
  logic             pend_q, pend_d;
  logic             ready_q, ready_d;
  logic             ack_q, ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [RW_AW-1:0] al_q, al_d;
  logic [RW_AW-1:0] ar_q, ar_d;
  logic [DW-1:0]    dl_q, dl_d;
  logic [DW-1:0]    dr_q, dr_d;
  logic             wel_q, wel_d;
  logic             wer_q, wer_d;

  // Next state: capture command, drive rw side, finish with ack
  always_comb begin
    s_we_d    = s_we_q;
    s_sel_d   = s_sel_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    pend_d    = pend_q;
    ready_d   = ready_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    al_d      = al_q;
    ar_d      = ar_q;
    dl_d      = dl_q;
    dr_d      = dr_q;
    wel_d     = 1'b0;
    wer_d     = 1'b0;

    if (go_wr_i || go_rd_i) begin
      if (s_sel_q == SEL_L) al_d = s_addr_q;
      else                  ar_d = s_addr_q;
    end

    if (go_wr_i) begin
      if (s_sel_q == SEL_L) begin
        dl_d  = s_wdata_q;
        wel_d = 1'b1;
      end else begin
        dr_d  = s_wdata_q;
        wer_d = 1'b1;
      end
      ack_d   = 1'b1;
      pend_d  = 1'b0;
      ready_d = 1'b1;
    end

    if (rd_cap_i) begin
      rdata_d = (s_sel_q == SEL_L) ? dout_l_i : dout_r_i;
      ack_d   = 1'b1;
      pend_d  = 1'b0;
      ready_d = 1'b1;
    end

    if (req_i && ready_q) begin
      s_we_d    = we_i;
      s_sel_d   = sel_i;
      s_addr_d  = addr_i;
      s_wdata_d = wdata_i;
      pend_d    = 1'b1;
      ready_d   = 1'b0;
    end
  end

  // Slot and rw port registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_we_q    <= 1'b0;
      s_sel_q   <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      pend_q    <= 1'b0;
      ready_q   <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      al_q      <= '0;
      ar_q      <= '0;
      dl_q      <= '0;
      dr_q      <= '0;
      wel_q     <= 1'b0;
      wer_q     <= 1'b0;
    end else begin
      s_we_q    <= s_we_d;
      s_sel_q   <= s_sel_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      pend_q    <= pend_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      al_q      <= al_d;
      ar_q      <= ar_d;
      dl_q      <= dl_d;
      dr_q      <= dr_d;
      wel_q     <= wel_d;
      wer_q     <= wer_d;
    end
  end

  assign pend_o    = pend_q;
  assign slot_we_o = s_we_q;
  assign ready_o   = ready_q;
  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign addr_l_o  = al_q;
  assign addr_r_o  = ar_q;
  assign din_l_o   = dl_q;
  assign din_r_o   = dr_q;
  assign we_l_o    = wel_q;
  assign we_r_o    = wer_q;

endmodule

// File: rtl/coef_ram_sequencer.sv
// Stereo coefficient RAM controller: per-frame address sweep
// plus host write/readback serialised between sweeps.
module coef_ram_sequencer
  import coef_seq_pkg::*;
#(
  parameter int BLK_AW = BLK_AW_D,
  parameter int RW_AW  = RW_AW_D,
  parameter int DW     = DW_D
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [BLK_AW-1:0] nblocks,
  output logic [BLK_AW-1:0] addrL,
  output logic [BLK_AW-1:0] addrR,
  output logic              coef_valid,
  output logic              coef_first,
  output logic              coef_last,
  output logic              done,
  output logic              busy,
  output logic              overrun,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_sel,
  input  logic [RW_AW-1:0]  host_addr,
  input  logic [DW-1:0]     host_wdata,
  output logic              host_ready,
  output logic              host_ack,
  output logic [DW-1:0]     host_rdata,
  output logic [RW_AW-1:0]  addrLrw,
  output logic [RW_AW-1:0]  addrRrw,
  output logic [DW-1:0]     datainLrw,
  output logic [DW-1:0]     datainRrw,
  output logic              weL,
  output logic              weR,
  input  logic [DW-1:0]     dataoutLrw,
  input  logic [DW-1:0]     dataoutRrw
);

  state_e            state_q, state_d;
  logic              spend_q, spend_d;
  logic [BLK_AW-1:0] nblk_q, nblk_d;
  logic [BLK_AW-1:0] lim_q, lim_d;
  logic [BLK_AW-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;

  logic in_sweep;
  logic enter_sweep;
  logic at_end;
  logic host_pend;
  logic slot_we;

  assign in_sweep    = (state_q == ST_SWEEP);
  assign enter_sweep = (state_q == ST_IDLE) && spend_q;
  assign at_end      = (addr_q == lim_q);

  // Next controller state; a pending frame start beats host commands
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (spend_q)        state_d = ST_SWEEP;
        else if (host_pend) state_d = slot_we ? ST_HWR : ST_HRD1;
      end
      ST_SWEEP: if (at_end) state_d = ST_IDLE;
      ST_HWR:   state_d = ST_IDLE;
      ST_HRD1:  state_d = ST_HRD2;
      ST_HRD2:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sweep datapath: start capture, address count, valid/flag pipeline
  always_comb begin
    spend_d = spend_q;
    nblk_d  = nblk_q;
    lim_d   = lim_q;
    addr_d  = addr_q;
    if (enter_sweep) begin
      spend_d = 1'b0;
      lim_d   = nblk_q;
      addr_d  = '0;
    end else if (in_sweep && !at_end) begin
      addr_d = addr_q + BLK_AW'(1);
    end
    if (start && !in_sweep) begin
      spend_d = 1'b1;
      nblk_d  = nblocks;
    end
    vld_d   = in_sweep;
    first_d = in_sweep && (addr_q == '0);
    last_d  = in_sweep && at_end;
    ovr_d   = start && in_sweep;
    busy_d  = (state_d == ST_SWEEP) || vld_d;
  end

  // Controller and sweep registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      spend_q <= 1'b0;
      nblk_q  <= '0;
      lim_q   <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      spend_q <= spend_d;
      nblk_q  <= nblk_d;
      lim_q   <= lim_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  coef_host_port #(
    .RW_AW (RW_AW),
    .DW    (DW)
  ) u_host (
    .clk_i     (clock),
    .rst_ni    (reset),
    .req_i     (host_req),
    .we_i      (host_we),
    .sel_i     (host_sel),
    .addr_i    (host_addr),
    .wdata_i   (host_wdata),
    .go_wr_i   (state_d == ST_HWR),
    .go_rd_i   (state_d == ST_HRD1),
    .rd_cap_i  (state_q == ST_HRD2),
    .pend_o    (host_pend),
    .slot_we_o (slot_we),
    .ready_o   (host_ready),
    .ack_o     (host_ack),
    .rdata_o   (host_rdata),
    .addr_l_o  (addrLrw),
    .addr_r_o  (addrRrw),
    .din_l_o   (datainLrw),
    .din_r_o   (datainRrw),
    .we_l_o    (weL),
    .we_r_o    (weR),
    .dout_l_i  (dataoutLrw),
    .dout_r_i  (dataoutRrw)
  );

  assign addrL      = addr_q;
  assign addrR      = addr_q;
  assign coef_valid = vld_q;
  assign coef_first = first_q;
  assign coef_last  = last_q;
  assign done       = last_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_coef_ram_sequencer.sv
// Directed bench for coef_ram_sequencer with a behavioural RAM
// and scoreboard queues for sweep, rw write and host ack events.
module tb_coef_ram_sequencer;

  localparam int BLK_AW = 11;
  localparam int RW_AW  = 14;
  localparam int DW     = 36;

  typedef struct packed {
    logic [BLK_AW-1:0] addr;
    logic              first;
    logic              last;
  } sw_t;

  typedef struct packed {
    logic             sel;
    logic [RW_AW-1:0] addr;
    logic [DW-1:0]    data;
  } wr_t;

  typedef struct packed {
    logic          rd;
    logic [DW-1:0] data;
  } ack_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [BLK_AW-1:0] nblocks = '0;
  logic [BLK_AW-1:0] addrL, addrR;
  logic              coef_valid, coef_first, coef_last, done, busy, overrun;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic              host_sel = 1'b0;
  logic [RW_AW-1:0]  host_addr = '0;
  logic [DW-1:0]     host_wdata = '0;
  logic              host_ready, host_ack;
  logic [DW-1:0]     host_rdata;
  logic [RW_AW-1:0]  addrLrw, addrRrw;
  logic [DW-1:0]     datainLrw, datainRrw;
  logic              weL, weR;
  logic [DW-1:0]     dataoutLrw, dataoutRrw;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  sw_t  sw_q[$];
  wr_t  wr_q[$];
  ack_t ack_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  coef_ram_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .nblocks    (nblocks),
    .addrL      (addrL),
    .addrR      (addrR),
    .coef_valid (coef_valid),
    .coef_first (coef_first),
    .coef_last  (coef_last),
    .done       (done),
    .busy       (busy),
    .overrun    (overrun),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_sel   (host_sel),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ready (host_ready),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .addrLrw    (addrLrw),
    .addrRrw    (addrRrw),
    .datainLrw  (datainLrw),
    .datainRrw  (datainRrw),
    .weL        (weL),
    .weR        (weR),
    .dataoutLrw (dataoutLrw),
    .dataoutRrw (dataoutRrw)
  );

  // RAM model: block index registered, word mux on live addr[2:0]
  logic [DW-1:0]      memL [0:(1<<RW_AW)-1];
  logic [DW-1:0]      memR [0:(1<<RW_AW)-1];
  logic [RW_AW-4:0]   blkL = '0;
  logic [RW_AW-4:0]   blkR = '0;

  always @(posedge clock) begin
    if (weL) memL[addrLrw] <= datainLrw;
    if (weR) memR[addrRrw] <= datainRrw;
    blkL <= addrLrw[RW_AW-1:3];
    blkR <= addrRrw[RW_AW-1:3];
  end

  assign dataoutLrw = memL[{blkL, addrLrw[2:0]}];
  assign dataoutRrw = memR[{blkR, addrRrw[2:0]}];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input int n);
    start   = 1'b1;
    nblocks = BLK_AW'(n);
    for (int i = 0; i <= n; i++)
      sw_q.push_back('{addr: BLK_AW'(i), first: (i == 0), last: (i == n)});
    tick();
    start = 1'b0;
  endtask

  task automatic do_host(input logic we, input logic sel,
                         input logic [RW_AW-1:0] a, input logic [DW-1:0] d);
    host_req   = 1'b1;
    host_we    = we;
    host_sel   = sel;
    host_addr  = a;
    host_wdata = we ? d : '0;
    if (we) wr_q.push_back('{sel: sel, addr: a, data: d});
    ack_q.push_back('{rd: !we, data: d});
    tick();
    host_req = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int dc);
    dc = -1;
    for (int i = 0; i < lim; i++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      tick();
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  logic [BLK_AW-1:0] prev_addr = '0;
  sw_t  se;
  wr_t  we_e;
  ack_t ae;

  always @(negedge clock) begin
    if (reset) begin
      check("addrR_eq_addrL", 64'(addrR), 64'(addrL));
      if (coef_valid) begin
        if (sw_q.size() == 0) begin
          check("sweep_extra", 64'(coef_valid), 64'd0);
        end else begin
          se = sw_q.pop_front();
          check("sweep_addr", 64'(prev_addr), 64'(se.addr));
          check("sweep_first", 64'(coef_first), 64'(se.first));
          check("sweep_last", 64'(coef_last), 64'(se.last));
          check("sweep_done", 64'(done), 64'(se.last));
        end
      end
      if (weL || weR) begin
        if (wr_q.size() == 0) begin
          check("we_extra", 64'(weL | weR), 64'd0);
        end else begin
          we_e = wr_q.pop_front();
          check("wr_weL", 64'(weL), 64'(we_e.sel == 1'b0));
          check("wr_weR", 64'(weR), 64'(we_e.sel == 1'b1));
          if (we_e.sel) begin
            check("wr_addrR", 64'(addrRrw), 64'(we_e.addr));
            check("wr_dataR", 64'(datainRrw), 64'(we_e.data));
          end else begin
            check("wr_addrL", 64'(addrLrw), 64'(we_e.addr));
            check("wr_dataL", 64'(datainLrw), 64'(we_e.data));
          end
        end
      end
      if (host_ack) begin
        if (ack_q.size() == 0) begin
          check("ack_extra", 64'(host_ack), 64'd0);
        end else begin
          ae = ack_q.pop_front();
          if (ae.rd) check("rd_data", 64'(host_rdata), 64'(ae.data));
        end
      end
    end
    prev_addr = addrL;
  end

  int t0, dc, dcyc, acyc, we_early, rdy_hi;

  initial begin
    #2 reset = 1'b0;
    tick();
    check("rst_addrL", 64'(addrL), 64'd0);
    check("rst_valid", 64'(coef_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(host_ready), 64'd1);
    check("rst_ack", 64'(host_ack), 64'd0);
    check("rst_we", 64'({weL, weR}), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    tick();
    tick();

    // Basic sweep, nblocks=3
    do_start(3);
    check("t1_busy_t0", 64'(busy), 64'd0);
    tick();
    check("t1_addr0", 64'(addrL), 64'd0);
    check("t1_busy_t1", 64'(busy), 64'd1);
    check("t1_valid_t1", 64'(coef_valid), 64'd0);
    tick();
    check("t1_valid_t2", 64'(coef_valid), 64'd1);
    check("t1_first_t2", 64'(coef_first), 64'd1);
    tick();
    tick();
    check("t1_addr3", 64'(addrL), 64'd3);
    tick();
    check("t1_last_t5", 64'(coef_last), 64'd1);
    check("t1_done_t5", 64'(done), 64'd1);
    check("t1_busy_t5", 64'(busy), 64'd1);
    tick();
    check("t1_busy_t6", 64'(busy), 64'd0);
    check("t1_addr_hold", 64'(addrL), 64'd3);

    // Single-block sweep
    do_start(0);
    tick();
    tick();
    check("t2_first", 64'(coef_first), 64'd1);
    check("t2_last", 64'(coef_last), 64'd1);
    check("t2_done", 64'(done), 64'd1);
    tick();
    check("t2_busy", 64'(busy), 64'd0);

    // Host write then readback, left RAM
    do_host(1'b1, 1'b0, 14'h0005, 36'h123456789);
    check("t3_ready_lo", 64'(host_ready), 64'd0);
    check("t3_ack_r0", 64'(host_ack), 64'd0);
    tick();
    check("t3_ack_r1", 64'(host_ack), 64'd1);
    check("t3_weL", 64'(weL), 64'd1);
    check("t3_weR", 64'(weR), 64'd0);
    check("t3_addr", 64'(addrLrw), 64'h5);
    check("t3_data", 64'(datainLrw), 64'h123456789);
    check("t3_ready_ack", 64'(host_ready), 64'd1);
    tick();
    check("t3_weL_off", 64'(weL), 64'd0);
    check("t3_ack_off", 64'(host_ack), 64'd0);
    do_host(1'b0, 1'b0, 14'h0005, 36'h123456789);
    check("t3r_ack_r0", 64'(host_ack), 64'd0);
    tick();
    check("t3r_ack_r1", 64'(host_ack), 64'd0);
    tick();
    check("t3r_ack_r2", 64'(host_ack), 64'd0);
    check("t3r_addr_hold", 64'(addrLrw), 64'h5);
    tick();
    check("t3r_ack_r3", 64'(host_ack), 64'd1);
    check("t3r_rdata", 64'(host_rdata), 64'h123456789);
    tick();
    check("t3r_ack_off", 64'(host_ack), 64'd0);
    check("t3r_rdata_hold", 64'(host_rdata), 64'h123456789);

    // Host write while a long sweep runs
    do_start(15);
    tick();
    tick();
    tick();
    do_host(1'b1, 1'b1, 14'h3FFF, 36'hABCDE0123);
    dcyc = -1; acyc = -1; we_early = 0; rdy_hi = 0;
    for (int i = 0; i < 60 && acyc < 0; i++) begin
      tick();
      if (done) dcyc = cyc;
      if (host_ack) acyc = cyc;
      else if (host_ready) rdy_hi++;
      if ((weL || weR) && dcyc < 0) we_early++;
    end
    check("t4_ack_seen", 64'(host_ack), 64'd1);
    check("t4_no_early_we", 64'(we_early), 64'd0);
    check("t4_ready_low", 64'(rdy_hi), 64'd0);
    check("t4_ack_after_done", 64'(acyc > dcyc && dcyc >= 0), 64'd1);
    tick();
    tick();

    // Start during sweep is rejected with overrun
    do_start(6);
    t0 = cyc;
    tick();
    tick();
    tick();
    start   = 1'b1;
    nblocks = 11'd2;
    tick();
    start = 1'b0;
    check("t5_overrun", 64'(overrun), 64'd1);
    tick();
    check("t5_overrun_off", 64'(overrun), 64'd0);
    wait_done(20, dc);
    check("t5_done_time", 64'(dc - t0), 64'd8);
    tick();
    tick();
    check("t5_busy_end", 64'(busy), 64'd0);

    // Start and host read in the same cycle: sweep first
    start      = 1'b1;
    nblocks    = 11'd2;
    for (int i = 0; i <= 2; i++)
      sw_q.push_back('{addr: BLK_AW'(i), first: (i == 0), last: (i == 2)});
    host_req   = 1'b1;
    host_we    = 1'b0;
    host_sel   = 1'b1;
    host_addr  = 14'h3FFF;
    ack_q.push_back('{rd: 1'b1, data: 36'hABCDE0123});
    tick();
    start    = 1'b0;
    host_req = 1'b0;
    dcyc = -1; acyc = -1;
    for (int i = 0; i < 40 && acyc < 0; i++) begin
      tick();
      if (done) dcyc = cyc;
      if (host_ack) acyc = cyc;
    end
    check("t6_ack_seen", 64'(host_ack), 64'd1);
    check("t6_ack_after_done", 64'(acyc > dcyc && dcyc >= 0), 64'd1);
    tick();

    // Reset in the middle of a sweep
    do_start(10);
    repeat (6) tick();
    check("t7_addr5", 64'(addrL), 64'd5);
    reset = 1'b0;
    sw_q.delete();
    #1;
    check("t7_addrL", 64'(addrL), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_valid", 64'(coef_valid), 64'd0);
    check("t7_ready", 64'(host_ready), 64'd1);
    check("t7_addrRrw", 64'(addrRrw), 64'd0);
    check("t7_datainRrw", 64'(datainRrw), 64'd0);
    check("t7_rdata", 64'(host_rdata), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    repeat (12) tick();
    do_start(4);
    tick();
    check("t7_restart_addr0", 64'(addrL), 64'd0);
    wait_done(20, dc);
    tick();
    tick();

    check("sw_q_drained", 64'(sw_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("ack_q_drained", 64'(ack_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coef_ram_sequencer.md
Name: coef_ram_sequencer

Overview:
Controller for the 8-bank stereo coefficient RAM. On each sample-frame start it sweeps the application read address (addrL/addrR) across the active filter length and flags when coefL/coefR are valid, first and last. Between sweeps it serialises host write and readback accesses onto the RAM's rw ports, so coefficients never change mid-sweep.

Parameters:
BLK_AW, 11, application block address width (2k blocks of 8 coefficients)
RW_AW, 14, host/rw word address width (16k coefficients)
DW, 36, coefficient word width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: new sample frame
nblocks  in  BLK_AW  last block index of the sweep; captured with start
addrL  out  BLK_AW  application read address, left RAM
addrR  out  BLK_AW  application read address, right RAM; always equals addrL
coef_valid  out  1  coefL/coefR valid this cycle
coef_first  out  1  with coef_valid: block 0
coef_last  out  1  with coef_valid: block nblocks
done  out  1  pulse coincident with coef_last
busy  out  1  sweep in progress
overrun  out  1  pulse: start rejected
host_req  in  1  one-cycle command pulse; legal only while host_ready=1
host_we  in  1  1=write, 0=read
host_sel  in  1  0=left RAM, 1=right RAM
host_addr  in  RW_AW  coefficient word address
host_wdata  in  DW  write data
host_ready  out  1  command slot free
host_ack  out  1  pulse: command complete
host_rdata  out  DW  read data; valid with host_ack, held until next read ack
addrLrw, addrRrw  out  RW_AW  RAM rw addresses
datainLrw, datainRrw  out  DW  RAM write data
weL, weR  out  1  RAM write enables
dataoutLrw, dataoutRrw  in  DW  RAM rw read data (registered, 1-cycle latency)

Behaviour:
- Reset (async, active-low): state IDLE. Every output 0 except host_ready=1. Pending flags cleared. Reset during a sweep aborts it: no done.
- States: IDLE, SWEEP, HWR, HRD1, HRD2. All outputs registered.
- Command capture: a host_req pulse latches we/sel/addr/wdata into a one-deep slot, sets host_pend and drops host_ready. host_ready returns to 1 in the host_ack cycle.
- Start capture:
  - In any state except SWEEP, start sets start_pend and latches nblocks.
  - In SWEEP, start is ignored and overrun pulses the next cycle.
- IDLE priority: start_pend first (goes to SWEEP), else host_pend (goes to HWR or HRD1), else stay.
- SWEEP timing: start accepted at edge t gives addr=0 at t+1 and increments each cycle to nblocks at t+1+nblocks, then IDLE.
  - coef_valid is addr-valid delayed one cycle, so it is high t+2..t+2+nblocks.
  - coef_first is asserted with the first valid; coef_last and done with the final valid.
  - nblocks=0 gives a single valid with first=last=1.
- busy = (state==SWEEP) | coef_valid. A start arriving in the coef_last cycle is accepted, giving back-to-back sweeps.
- HWR (1 cycle): drive the selected rw address and data with we=1 for that cycle only; host_ack pulses in the same cycle. The unselected side's we stays 0.
- HRD1 then HRD2: hold the selected rw address stable for both cycles, because the RAM output mux uses addr[2:0] combinationally.
  - Capture the selected dataout at the end of HRD2.
  - host_ack and host_rdata appear in the following cycle (back in IDLE).
- Host-to-ack latency with no contention: write 2 cycles, read 4 cycles.
- rw addresses and data hold their last value when idle; we is 0 outside HWR.
- addrL/addrR hold their last value after a sweep; coefL/coefR outside coef_valid are don't-care.

Decomposition:
- Package coef_seq_pkg holds the state enum, BLK_AW/RW_AW/DW defaults and the SEL_L/SEL_R constants.
- One sub-module, coef_host_port: command slot, host_ready, rw port drive, read capture and ack. The top FSM grants it only in IDLE.

Test Plan:
- Reset, then start with nblocks=3 at edge t → addrL=addrR=0,1,2,3 at t+1..t+4. coef_valid at t+2..t+5; first at t+2; last and done at t+5; busy low at t+6.
- Host write sel=0, addr=0x0005, data=0x123456789 → weL=1 for one cycle with addrLrw=0x0005 and datainLrw=0x123456789; weR=0; ack 2 cycles after req. Readback returns rdata=0x123456789 with ack 4 cycles after req.
- Host write request during a sweep with nblocks=15 → no we asserted until the sweep ends; host_ready stays low; ack comes after the last addr cycle.
- start pulse mid-sweep → overrun pulses once; the address sequence and done timing are unchanged.
- start and host_req in the same IDLE cycle → full sweep runs first, then the host op; ack follows done.
- reset asserted at addr=5 of an nblocks=10 sweep → all outputs 0 and host_ready=1 immediately, no done. A new start after release sweeps correctly from 0.
